// File: rtl/memory_pkg.sv
// Shared types and helpers for the memory card game controller.
package memory_pkg;

    localparam int SYM_W     = 3;
    localparam int FORMATO_W = 5;

    typedef enum logic [1:0] {
        HIDDEN  = 2'b00,
        UP      = 2'b01,
        MATCHED = 2'b10
    } card_state_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FIRST   = 3'd1,
        ST_SECOND  = 3'd2,
        ST_COMPARE = 3'd3,
        ST_SHOW    = 3'd4,
        ST_DONE    = 3'd5
    } match_state_t;

    function automatic logic [FORMATO_W-1:0] pack_formato(input logic [SYM_W-1:0] sym,
                                                          input card_state_t     st);
        return {sym, st};
    endfunction

endpackage

// File: rtl/flip_timer.sv
// Loadable down-counter; holds at zero. Used for the mismatch display delay and the turn timeout.
module flip_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic [WIDTH-1:0] value,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (en && (value != '0)) begin
            value <= value - 1'b1;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/memory_match_ctrl.sv
// Game-flow controller for the memory card game: selection, pair compare, mismatch display delay.
// Optional feature macro: MEMORY_TURN_TIMEOUT_EN (flip a lone face-up card back after idling).
module memory_match_ctrl
    import memory_pkg::*;
#(
    parameter int unsigned N_CARDS      = 16,
    parameter int unsigned FLIP_DELAY   = 50_000_000,
    parameter int unsigned TURN_TIMEOUT = 250_000_000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [N_CARDS*SYM_W-1:0]       sym_table,
    input  logic                           sel_valid,
    input  logic [3:0]                     sel_idx,
    output logic [N_CARDS*FORMATO_W-1:0]   formato,
    output logic                           match_pulse,
    output logic                           mismatch_pulse,
    output logic [3:0]                     pairs_found,
    output logic [7:0]                     attempts,
    output logic                           busy,
    output logic                           game_over
);

    localparam int unsigned FW = $clog2(FLIP_DELAY + 1);

    if ((N_CARDS % 2 != 0) || (N_CARDS == 0) || (N_CARDS > 16) || (FLIP_DELAY < 1) ||
        (TURN_TIMEOUT < 1)) begin : g_param_check
        $error("memory_match_ctrl: illegal parameter value");
    end

    match_state_t               state_q, state_d;
    card_state_t                est_q [N_CARDS];
    card_state_t                est_d [N_CARDS];
    logic [N_CARDS*SYM_W-1:0]   sym_q, sym_d;
    logic [3:0]                 idx_a_q, idx_a_d, idx_b_q, idx_b_d;
    logic [3:0]                 pairs_q, pairs_d;
    logic [7:0]                 attempts_q, attempts_d;
    logic                       match_q, match_d, mismatch_q, mismatch_d;
    logic                       busy_q, game_over_q;

    card_state_t                sel_st;
    logic [SYM_W-1:0]           sym_a, sym_b;
    logic                       sel_ok;

    logic                       ft_load, ft_en, ft_zero;
    logic [FW-1:0]              ft_load_value, ft_value;

    flip_timer #(.WIDTH(FW)) u_flip_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (ft_load),
        .load_value (ft_load_value),
        .en         (ft_en),
        .value      (ft_value),
        .zero       (ft_zero)
    );

`ifdef MEMORY_TURN_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TURN_TIMEOUT + 1);
    logic          to_load, to_zero, to_expire;
    logic [TW-1:0] to_value;

    flip_timer #(.WIDTH(TW)) u_turn_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (to_load),
        .load_value (TW'(TURN_TIMEOUT)),
        .en         (state_q == ST_SECOND),
        .value      (to_value),
        .zero       (to_zero)
    );

    assign to_expire = (state_q == ST_SECOND) && (to_zero || (to_value == TW'(1)));
`endif

    always_comb begin
        sel_st = HIDDEN;
        sym_a  = '0;
        sym_b  = '0;
        for (int i = 0; i < int'(N_CARDS); i++) begin
            if (sel_idx == 4'(i)) sel_st = est_q[i];
            if (idx_a_q == 4'(i)) sym_a = sym_q[i*SYM_W +: SYM_W];
            if (idx_b_q == 4'(i)) sym_b = sym_q[i*SYM_W +: SYM_W];
        end
        sel_ok = sel_valid && ({28'd0, sel_idx} < N_CARDS) && (sel_st == HIDDEN);
    end

    always_comb begin
        state_d       = state_q;
        est_d         = est_q;
        sym_d         = sym_q;
        idx_a_d       = idx_a_q;
        idx_b_d       = idx_b_q;
        pairs_d       = pairs_q;
        attempts_d    = attempts_q;
        match_d       = 1'b0;
        mismatch_d    = 1'b0;
        ft_load       = 1'b0;
        ft_load_value = FW'(FLIP_DELAY);
        ft_en         = (state_q == ST_SHOW);
`ifdef MEMORY_TURN_TIMEOUT_EN
        to_load       = 1'b0;
`endif
        if (start) begin
            state_d       = ST_FIRST;
            est_d         = '{default: HIDDEN};
            sym_d         = sym_table;
            idx_a_d       = '0;
            idx_b_d       = '0;
            pairs_d       = '0;
            attempts_d    = '0;
            ft_load       = 1'b1;
            ft_load_value = '0;
        end else begin
            unique case (state_q)
                ST_FIRST: begin
                    if (sel_ok) begin
                        for (int i = 0; i < int'(N_CARDS); i++)
                            if (sel_idx == 4'(i)) est_d[i] = UP;
                        idx_a_d = sel_idx;
                        state_d = ST_SECOND;
`ifdef MEMORY_TURN_TIMEOUT_EN
                        to_load = 1'b1;
`endif
                    end
                end
                ST_SECOND: begin
                    if (sel_ok && (sel_idx != idx_a_q)) begin
                        for (int i = 0; i < int'(N_CARDS); i++)
                            if (sel_idx == 4'(i)) est_d[i] = UP;
                        idx_b_d = sel_idx;
                        state_d = ST_COMPARE;
                    end
`ifdef MEMORY_TURN_TIMEOUT_EN
                    else if (to_expire) begin
                        for (int i = 0; i < int'(N_CARDS); i++)
                            if (idx_a_q == 4'(i)) est_d[i] = HIDDEN;
                        state_d = ST_FIRST;
                    end
`endif
                end
                ST_COMPARE: begin
                    attempts_d = (attempts_q == 8'hFF) ? attempts_q : attempts_q + 8'd1;
                    if (sym_a == sym_b) begin
                        for (int i = 0; i < int'(N_CARDS); i++)
                            if ((idx_a_q == 4'(i)) || (idx_b_q == 4'(i))) est_d[i] = MATCHED;
                        pairs_d = pairs_q + 4'd1;
                        match_d = 1'b1;
                        state_d = (pairs_d == 4'(N_CARDS / 2)) ? ST_DONE : ST_FIRST;
                    end else begin
                        ft_load = 1'b1;
                        state_d = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    // Flip on the edge where the count reaches zero, so SHOW lasts FLIP_DELAY cycles.
                    if (ft_zero || (ft_value == FW'(1))) begin
                        for (int i = 0; i < int'(N_CARDS); i++)
                            if ((idx_a_q == 4'(i)) || (idx_b_q == 4'(i))) est_d[i] = HIDDEN;
                        mismatch_d = 1'b1;
                        state_d    = ST_FIRST;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            est_q       <= '{default: HIDDEN};
            sym_q       <= '0;
            idx_a_q     <= '0;
            idx_b_q     <= '0;
            pairs_q     <= '0;
            attempts_q  <= '0;
            match_q     <= 1'b0;
            mismatch_q  <= 1'b0;
            busy_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            est_q       <= est_d;
            sym_q       <= sym_d;
            idx_a_q     <= idx_a_d;
            idx_b_q     <= idx_b_d;
            pairs_q     <= pairs_d;
            attempts_q  <= attempts_d;
            match_q     <= match_d;
            mismatch_q  <= mismatch_d;
            busy_q      <= (state_d == ST_COMPARE) || (state_d == ST_SHOW);
            game_over_q <= (state_d == ST_DONE);
        end
    end

    for (genvar g = 0; g < int'(N_CARDS); g++) begin : g_formato
        assign formato[g*FORMATO_W +: FORMATO_W] = pack_formato(sym_q[g*SYM_W +: SYM_W], est_q[g]);
    end

    assign match_pulse    = match_q;
    assign mismatch_pulse = mismatch_q;
    assign pairs_found    = pairs_q;
    assign attempts       = attempts_q;
    assign busy           = busy_q;
    assign game_over      = game_over_q;

endmodule

// File: tb/tb_memory_match_ctrl.sv
// Self-checking bench for memory_match_ctrl against a card-list reference model.
module tb_memory_match_ctrl;

    localparam int N  = 16;
    localparam int FD = 4;
    localparam int TT = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [47:0]   sym_table;
    logic          sel_valid = 1'b0;
    logic [3:0]    sel_idx = '0;
    logic [79:0]   formato;
    logic          match_pulse, mismatch_pulse, busy, game_over;
    logic [3:0]    pairs_found;
    logic [7:0]    attempts;

    logic [69:0]   formato14;
    logic          match14, mismatch14, busy14, over14;
    logic [3:0]    pairs14;
    logic [7:0]    att14;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    memory_match_ctrl #(.N_CARDS(N), .FLIP_DELAY(FD), .TURN_TIMEOUT(TT)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .sym_table      (sym_table),
        .sel_valid      (sel_valid),
        .sel_idx        (sel_idx),
        .formato        (formato),
        .match_pulse    (match_pulse),
        .mismatch_pulse (mismatch_pulse),
        .pairs_found    (pairs_found),
        .attempts       (attempts),
        .busy           (busy),
        .game_over      (game_over)
    );

    memory_match_ctrl #(.N_CARDS(14), .FLIP_DELAY(FD), .TURN_TIMEOUT(TT)) u_dut14 (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .sym_table      (sym_table[41:0]),
        .sel_valid      (sel_valid),
        .sel_idx        (sel_idx),
        .formato        (formato14),
        .match_pulse    (match14),
        .mismatch_pulse (mismatch14),
        .pairs_found    (pairs14),
        .attempts       (att14),
        .busy           (busy14),
        .game_over      (over14)
    );

    // Reference model: which cards are matched, which are face up, and pending work.
    bit [2:0] m_sym [N];
    bit       m_matched [N];
    int       m_up [$];
    int       m_show;
    bit       m_cmp;
    bit       m_active;
    int       m_pairs;
    int       m_att;
    bit       m_mp, m_mmp;
    int       m_to;

    function automatic bit m_is_up(int k);
        foreach (m_up[j]) if (m_up[j] == k) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        bit accepted;
        m_mp  = 1'b0;
        m_mmp = 1'b0;
        if (rst || start) begin
            for (int i = 0; i < N; i++) begin
                m_sym[i]     = rst ? 3'd0 : sym_table[3*i +: 3];
                m_matched[i] = 1'b0;
            end
            m_up.delete();
            m_show = 0; m_cmp = 1'b0; m_pairs = 0; m_att = 0; m_to = 0;
            m_active = !rst;
            return;
        end
        if (m_cmp) begin
            m_cmp = 1'b0;
            m_att = (m_att < 255) ? m_att + 1 : 255;
            if (m_sym[m_up[0]] == m_sym[m_up[1]]) begin
                m_matched[m_up[0]] = 1'b1;
                m_matched[m_up[1]] = 1'b1;
                m_up.delete();
                m_pairs++;
                m_mp = 1'b1;
            end else begin
                m_show = FD;
            end
        end else if (m_show > 0) begin
            m_show--;
            if (m_show == 0) begin
                m_up.delete();
                m_mmp = 1'b1;
            end
        end else if (m_active && m_pairs < N / 2) begin
            accepted = 1'b0;
            if (sel_valid && int'(sel_idx) < N && !m_matched[sel_idx] && !m_is_up(int'(sel_idx))) begin
                m_up.push_back(int'(sel_idx));
                accepted = 1'b1;
                if (m_up.size() == 2) m_cmp = 1'b1;
                else m_to = TT;
            end
`ifdef MEMORY_TURN_TIMEOUT_EN
            if (!accepted && m_up.size() == 1) begin
                m_to--;
                if (m_to == 0) m_up.delete();
            end
`endif
        end
    endtask

    function automatic logic [95:0] exp_bundle();
        logic [79:0] f;
        logic [1:0]  st;
        for (int i = 0; i < N; i++) begin
            st = m_matched[i] ? 2'b10 : (m_is_up(i) ? 2'b01 : 2'b00);
            f[5*i +: 5] = {m_sym[i], st};
        end
        return {f, m_mp, m_mmp, 4'(m_pairs), 8'(m_att), (m_cmp || m_show > 0),
                (m_pairs == N / 2)};
    endfunction

    function automatic logic [95:0] obs_bundle();
        return {formato, match_pulse, mismatch_pulse, pairs_found, attempts, busy, game_over};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        start     = 1'b0;
        sel_valid = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic pick(input int k);
        sel_valid = 1'b1;
        sel_idx   = 4'(k);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if (obs_bundle() !== 96'd0) begin
            failures++;
            $display("FAIL reset_values: got %h want 0", obs_bundle());
        end
        checks++;
        if (obs_bundle() !== exp_bundle()) begin
            failures++;
            $display("FAIL reset_model: got %h want %h", obs_bundle(), exp_bundle());
        end
    endtask

    task automatic test_match();
        start = 1'b1;
        tick();
        pick(0); tick();
        checks++;
        if (formato[1:0] !== 2'b01 || obs_bundle() !== exp_bundle()) begin
            failures++;
            $display("FAIL first_up: got %h want %h", obs_bundle(), exp_bundle());
        end
        pick(1); tick();
        checks++;
        if (formato[6:5] !== 2'b01 || busy !== 1'b1 || obs_bundle() !== exp_bundle()) begin
            failures++;
            $display("FAIL second_up: got %h want %h", obs_bundle(), exp_bundle());
        end
        tick();
        checks++;
        if (formato[4:0] !== 5'b000_10 || match_pulse !== 1'b1 || pairs_found !== 4'd1 ||
            attempts !== 8'd1) begin
            failures++;
            $display("FAIL match_result: got f=%b mp=%b pairs=%0d att=%0d want f=00010 mp=1 pairs=1 att=1",
                     formato[4:0], match_pulse, pairs_found, attempts);
        end
        checks++;
        if (obs_bundle() !== exp_bundle()) begin
            failures++;
            $display("FAIL match_model: got %h want %h", obs_bundle(), exp_bundle());
        end
    endtask

    task automatic test_mismatch();
        int busy_cnt;
        pick(2); tick();
        pick(4); tick();
        busy_cnt = 0;
        for (int c = 0; c < 20 && busy === 1'b1; c++) begin
            busy_cnt++;
            tick();
            checks++;
            if (obs_bundle() !== exp_bundle()) begin
                failures++;
                $display("FAIL mismatch_cycle%0d: got %h want %h", c, obs_bundle(), exp_bundle());
            end
        end
        checks++;
        if (busy_cnt !== 5) begin
            failures++;
            $display("FAIL busy_len: got %0d want 5", busy_cnt);
        end
        checks++;
        if (mismatch_pulse !== 1'b1 || formato[11:10] !== 2'b00 || formato[21:20] !== 2'b00 ||
            pairs_found !== 4'd1) begin
            failures++;
            $display("FAIL mismatch_flip: got mmp=%b c2=%b c4=%b pairs=%0d want 1 00 00 1",
                     mismatch_pulse, formato[11:10], formato[21:20], pairs_found);
        end
    endtask

    task automatic test_ignored();
        logic [79:0] prev;
        logic [69:0] prev14;
        prev = formato;
        pick(0); tick();
        checks++;
        if (formato !== prev || obs_bundle() !== exp_bundle()) begin
            failures++;
            $display("FAIL sel_matched: got %h want %h", formato, prev);
        end
        pick(5); tick();
        prev = formato;
        pick(5); tick();
        checks++;
        if (formato !== prev || formato[26:25] !== 2'b01 || obs_bundle() !== exp_bundle()) begin
            failures++;
            $display("FAIL sel_repeat: got %h want %h", formato, prev);
        end
        pick(6); tick();
        tick();
        prev = formato;
        pick(7); tick();
        checks++;
        if (formato !== prev || obs_bundle() !== exp_bundle()) begin
            failures++;
            $display("FAIL sel_in_show: got %h want %h", formato, prev);
        end
        for (int w = 0; w < 20 && busy === 1'b1; w++) tick();
        checks++;
        if (busy !== 1'b0 || obs_bundle() !== exp_bundle()) begin
            failures++;
            $display("FAIL show_exit: got %h want %h", obs_bundle(), exp_bundle());
        end
        prev14 = formato14;
        pick(15); tick();
        checks++;
        if (formato14 !== prev14) begin
            failures++;
            $display("FAIL sel_out_of_range: got %h want %h", formato14, prev14);
        end
        checks++;
        if (formato[76:75] !== 2'b01 || obs_bundle() !== exp_bundle()) begin
            failures++;
            $display("FAIL sel_15_n16: got %h want %h", obs_bundle(), exp_bundle());
        end
    endtask

    task automatic test_game_over();
        int cand [$];
        int a, b;
        logic [79:0] prev;
        logic        any_up;
        start = 1'b1;
        tick();
        for (int it = 0; it < 300 && m_pairs < N / 2; it++) begin
            cand.delete();
            for (int i = 0; i < N; i++) if (!m_matched[i]) cand.push_back(i);
            a = cand[$urandom_range(cand.size() - 1)];
            b = a ^ 1;
            if ($urandom_range(1) == 0) begin
                do b = cand[$urandom_range(cand.size() - 1)]; while (b == a);
            end
            pick(a); tick();
            pick(b); tick();
            checks++;
            if (obs_bundle() !== exp_bundle()) begin
                failures++;
                $display("FAIL game_sel it%0d: got %h want %h", it, obs_bundle(), exp_bundle());
            end
            for (int w = 0; w < 20 && busy === 1'b1; w++) begin
                if ($urandom_range(3) == 0) pick($urandom_range(15));
                tick();
                checks++;
                if (obs_bundle() !== exp_bundle()) begin
                    failures++;
                    $display("FAIL game_busy it%0d: got %h want %h", it, obs_bundle(), exp_bundle());
                end
            end
        end
        checks++;
        if (game_over !== 1'b1 || pairs_found !== 4'd8) begin
            failures++;
            $display("FAIL game_over: got over=%b pairs=%0d want 1 8", game_over, pairs_found);
        end
        prev = formato;
        pick(0); tick();
        checks++;
        if (formato !== prev || game_over !== 1'b1 || obs_bundle() !== exp_bundle()) begin
            failures++;
            $display("FAIL sel_after_done: got %h want %h", formato, prev);
        end
        start = 1'b1;
        tick();
        any_up = 1'b0;
        for (int i = 0; i < N; i++) if (formato[5*i +: 2] !== 2'b00) any_up = 1'b1;
        checks++;
        if (any_up !== 1'b0 || game_over !== 1'b0 || pairs_found !== 4'd0 ||
            obs_bundle() !== exp_bundle()) begin
            failures++;
            $display("FAIL restart: got %h want %h", obs_bundle(), exp_bundle());
        end
    endtask

    task automatic test_rst_and_priority();
        logic any_up;
        pick(0); tick();
        pick(2); tick();
        tick();
        tick();
        checks++;
        if (busy !== 1'b1 || obs_bundle() !== exp_bundle()) begin
            failures++;
            $display("FAIL pre_rst_show: got %h want %h", obs_bundle(), exp_bundle());
        end
        rst = 1'b1;
        tick();
        checks++;
        if (obs_bundle() !== 96'd0) begin
            failures++;
            $display("FAIL rst_mid_show: got %h want 0", obs_bundle());
        end
        start = 1'b1;
        pick(3);
        tick();
        any_up = 1'b0;
        for (int i = 0; i < N; i++) if (formato[5*i +: 2] !== 2'b00) any_up = 1'b1;
        checks++;
        if (any_up !== 1'b0 || obs_bundle() !== exp_bundle()) begin
            failures++;
            $display("FAIL start_priority: got %h want %h", obs_bundle(), exp_bundle());
        end
    endtask

`ifdef MEMORY_TURN_TIMEOUT_EN
    task automatic test_timeout();
        pick(3); tick();
        for (int c = 0; c < TT; c++) begin
            tick();
            checks++;
            if (obs_bundle() !== exp_bundle()) begin
                failures++;
                $display("FAIL timeout_cycle%0d: got %h want %h", c, obs_bundle(), exp_bundle());
            end
        end
        checks++;
        if (formato[16:15] !== 2'b00 || attempts !== 8'd0) begin
            failures++;
            $display("FAIL timeout_hide: got c3=%b att=%0d want 00 0", formato[16:15], attempts);
        end
        pick(6); tick();
        pick(7); tick();
        tick();
        checks++;
        if (match_pulse !== 1'b1 || obs_bundle() !== exp_bundle()) begin
            failures++;
            $display("FAIL timeout_first: got %h want %h", obs_bundle(), exp_bundle());
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < N; i++) sym_table[3*i +: 3] = 3'(i >> 1);
        test_reset();
        test_match();
        test_mismatch();
        test_ignored();
        test_game_over();
        test_rst_and_priority();
`ifdef MEMORY_TURN_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
